// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Optional FWD_STALL_CNT_EN adds a free-running 32-bit stall-cycle counter.
package fwd_hazard_pkg;
    typedef enum logic [1:0] {
        FW_NONE    = 2'b00,
        FW_MEM_ALU = 2'b01,
        FW_WB_DATA = 2'b10
    } fw_sel_e;
endpackage

module fwd_hazard_unit
    import fwd_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rs1_addr_i,
    input  logic [4:0]  ex_rs2_addr_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_mem_read_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    output fw_sel_e     fw_sel_rs1_o,
    output fw_sel_e     fw_sel_rs2_o,
    output logic        stall_o,
    output logic        hazard_err_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    logic       mem_valid, mem_we, mem_ld;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_we;
    logic [4:0] wb_rd;

    // Shadows advance unconditionally; the core is responsible for bubbling EX on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_rd    <= 5'd0;
            mem_we    <= 1'b0;
            mem_ld    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_we     <= 1'b0;
        end else begin
            mem_valid <= ex_valid_i;
            mem_rd    <= ex_rd_addr_i;
            mem_we    <= ex_reg_write_i;
            mem_ld    <= ex_mem_read_i;
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_we     <= mem_we;
        end
    end

    logic mem_prod, wb_prod;
    assign mem_prod = mem_valid & mem_we & (mem_rd != 5'd0);
    assign wb_prod  = wb_valid & wb_we & (wb_rd != 5'd0);

    logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic err1, err2;

    // A matching load in MEM has no data yet, so it blocks WB forwarding and flags an error.
    always_comb begin
        fw_sel_rs1_o = FW_NONE;
        fw_sel_rs2_o = FW_NONE;
        mem_hit1 = ex_valid_i & mem_prod & (ex_rs1_addr_i != 5'd0) & (ex_rs1_addr_i == mem_rd);
        mem_hit2 = ex_valid_i & mem_prod & (ex_rs2_addr_i != 5'd0) & (ex_rs2_addr_i == mem_rd);
        wb_hit1  = ex_valid_i & wb_prod & (ex_rs1_addr_i != 5'd0) & (ex_rs1_addr_i == wb_rd);
        wb_hit2  = ex_valid_i & wb_prod & (ex_rs2_addr_i != 5'd0) & (ex_rs2_addr_i == wb_rd);
        err1 = mem_hit1 & mem_ld;
        err2 = mem_hit2 & mem_ld;

        if (mem_hit1) begin
            if (!mem_ld) fw_sel_rs1_o = FW_MEM_ALU;
        end else if (wb_hit1) begin
            fw_sel_rs1_o = FW_WB_DATA;
        end

        if (mem_hit2) begin
            if (!mem_ld) fw_sel_rs2_o = FW_MEM_ALU;
        end else if (wb_hit2) begin
            fw_sel_rs2_o = FW_WB_DATA;
        end
    end

    assign hazard_err_o = err1 | err2;

    assign stall_o = id_valid_i & ex_valid_i & ex_mem_read_i & ex_reg_write_i &
                     (ex_rd_addr_i != 5'd0) &
                     ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                      (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       stall_cnt_o <= 32'd0;
        else if (stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against a history-queue reference model.
module tb_fwd_hazard_unit;
    import fwd_hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ex_valid_i = 1'b0;
    logic [4:0] ex_rs1_addr_i = '0, ex_rs2_addr_i = '0, ex_rd_addr_i = '0;
    logic       ex_reg_write_i = 1'b0, ex_mem_read_i = 1'b0;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs1_addr_i = '0, id_rs2_addr_i = '0;
    logic       id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
    fw_sel_e    fw_sel_rs1_o, fw_sel_rs2_o;
    logic       stall_o, hazard_err_o;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int vectorCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .fw_sel_rs1_o(fw_sel_rs1_o), .fw_sel_rs2_o(fw_sel_rs2_o),
        .stall_o(stall_o), .hazard_err_o(hazard_err_o)
`ifdef FWD_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    // Reference model: queue of retired EX instructions, index 0 = one cycle ago (MEM), 1 = two ago (WB).
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } instr_t;
    instr_t history[$];
    int unsigned modelStallCnt = 0;

    function automatic bit writesReg(input int slot, input bit [4:0] r);
        if (history.size() <= slot) return 1'b0;
        return history[slot].valid && history[slot].we && history[slot].rd != 0 && history[slot].rd == r;
    endfunction

    // Returns {err, sel} for one EX source operand.
    function automatic bit [2:0] expectOperand(input bit [4:0] r);
        if (!ex_valid_i || r == 0) return {1'b0, FW_NONE};
        if (writesReg(0, r)) return history[0].ld ? {1'b1, FW_NONE} : {1'b0, FW_MEM_ALU};
        if (writesReg(1, r)) return {1'b0, FW_WB_DATA};
        return {1'b0, FW_NONE};
    endfunction

    function automatic bit expectStall();
        bit loadInEx = ex_valid_i && ex_mem_read_i && ex_reg_write_i && ex_rd_addr_i != 0;
        bit reads = (id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
                    (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i);
        return id_valid_i && loadInEx && reads;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkModel();
        bit [2:0] e1 = expectOperand(ex_rs1_addr_i);
        bit [2:0] e2 = expectOperand(ex_rs2_addr_i);
        checkOutput("sel_rs1", 32'(fw_sel_rs1_o), 32'(e1[1:0]));
        checkOutput("sel_rs2", 32'(fw_sel_rs2_o), 32'(e2[1:0]));
        checkOutput("hazard_err", 32'(hazard_err_o), 32'(e1[2] | e2[2]));
        checkOutput("stall", 32'(stall_o), 32'(expectStall()));
`ifdef FWD_STALL_CNT_EN
        checkOutput("stall_cnt", stall_cnt_o, modelStallCnt);
`endif
    endtask

    task automatic applyStimulus(input bit ev, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                                 input bit we, input bit ld, input bit iv, input bit [4:0] irs1,
                                 input bit [4:0] irs2, input bit u1, input bit u2);
        @(negedge clk);
        ex_valid_i = ev; ex_rs1_addr_i = rs1; ex_rs2_addr_i = rs2; ex_rd_addr_i = rd;
        ex_reg_write_i = we; ex_mem_read_i = ld;
        id_valid_i = iv; id_rs1_addr_i = irs1; id_rs2_addr_i = irs2;
        id_rs1_used_i = u1; id_rs2_used_i = u2;
        #2;
    endtask

    // Model state advances at the edge, after the current cycle has been checked.
    task automatic advance();
        instr_t cur;
        bit st = expectStall();
        cur.valid = ex_valid_i; cur.rd = ex_rd_addr_i; cur.we = ex_reg_write_i; cur.ld = ex_mem_read_i;
        @(posedge clk);
        if (rst_n) begin
            if (st) modelStallCnt++;
            history.push_front(cur);
            if (history.size() > 2) void'(history.pop_back());
        end
    endtask

    task automatic step(input bit ev, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                        input bit we, input bit ld);
        applyStimulus(ev, rs1, rs2, rd, we, ld, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkModel();
        advance();
    endtask

    task automatic resetPulse();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        history.delete();
        modelStallCnt = 0;
        #1;
        checkOutput("rst_sel_rs1", 32'(fw_sel_rs1_o), 32'(FW_NONE));
        checkOutput("rst_sel_rs2", 32'(fw_sel_rs2_o), 32'(FW_NONE));
        checkOutput("rst_err", 32'(hazard_err_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        resetPulse();

        // add x5 then sub x6,x5,x5
        step(1, 5'd1, 5'd2, 5'd5, 1, 0);
        applyStimulus(1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 0, 0, 0);
        checkModel();
        checkOutput("d022_rs1", 32'(fw_sel_rs1_o), 32'(FW_MEM_ALU));
        checkOutput("d022_rs2", 32'(fw_sel_rs2_o), 32'(FW_MEM_ALU));
        advance();

        // add x5; nop; or x7,x5,x0
        step(1, 5'd1, 5'd2, 5'd5, 1, 0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0);
        applyStimulus(1, 5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 0, 0, 0);
        checkModel();
        checkOutput("d023_rs1", 32'(fw_sel_rs1_o), 32'(FW_WB_DATA));
        checkOutput("d023_rs2", 32'(fw_sel_rs2_o), 32'(FW_NONE));
        advance();

        // add x5 (WB), addi x5 (MEM), EX reads x5
        step(1, 5'd1, 5'd2, 5'd5, 1, 0);
        step(1, 5'd5, 5'd0, 5'd5, 1, 0);
        applyStimulus(1, 5'd5, 5'd3, 5'd9, 1, 0, 0, 0, 0, 0, 0);
        checkModel();
        checkOutput("d024_rs1", 32'(fw_sel_rs1_o), 32'(FW_MEM_ALU));
        advance();

        // lw x8 in EX with add x9,x8,x1 in ID, bubble, then add in EX
        applyStimulus(1, 5'd2, 5'd0, 5'd8, 1, 1, 1, 5'd8, 5'd1, 1, 1);
        checkModel();
        checkOutput("d025_stall", 32'(stall_o), 32'd1);
        advance();
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'd8, 5'd1, 1, 1);
        checkModel();
        checkOutput("d025_unstall", 32'(stall_o), 32'd0);
`ifdef FWD_STALL_CNT_EN
        checkOutput("d025_cnt", stall_cnt_o, 32'd1);
`endif
        advance();
        applyStimulus(1, 5'd8, 5'd1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
        checkModel();
        checkOutput("d025_fwd", 32'(fw_sel_rs1_o), 32'(FW_WB_DATA));
        advance();

        // lw x0 with ID reading x0, then reader of x0
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 5'd0, 1, 1);
        checkModel();
        checkOutput("d026_stall", 32'(stall_o), 32'd0);
        advance();
        applyStimulus(1, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 0, 0, 0);
        checkModel();
        checkOutput("d026_x0", 32'(fw_sel_rs1_o), 32'(FW_NONE));
        advance();

        // Load in MEM read by EX raises hazard_err
        step(1, 5'd0, 5'd0, 5'd3, 1, 1);
        applyStimulus(1, 5'd3, 5'd0, 5'd4, 1, 0, 0, 0, 0, 0, 0);
        checkModel();
        checkOutput("err_flag", 32'(hazard_err_o), 32'd1);
        advance();

        // Producer in MEM discarded by reset
        step(1, 5'd1, 5'd2, 5'd5, 1, 0);
        resetPulse();
        applyStimulus(1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 0, 0, 0);
        checkModel();
        checkOutput("d027_rs1", 32'(fw_sel_rs1_o), 32'(FW_NONE));
        checkOutput("d027_err", 32'(hazard_err_o), 32'd0);
        advance();

        // Randomized traffic on a small register window so hits are frequent
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) resetPulse();
            applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkModel();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port list SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- ex_valid_i  in  1  EX slot holds a real instruction (0 = bubble)
- ex_rs1_addr_i  in  5  EX source 1
- ex_rs2_addr_i  in  5  EX source 2
- ex_rd_addr_i  in  5  EX destination
- ex_reg_write_i  in  1  EX writes rd
- ex_mem_read_i  in  1  EX is a load
- id_valid_i  in  1  ID slot valid
- id_rs1_addr_i  in  5  ID source 1
- id_rs2_addr_i  in  5  ID source 2
- id_rs1_used_i  in  1  ID reads rs1
- id_rs2_used_i  in  1  ID reads rs2
- fw_sel_rs1_o  out  fw_sel_e  operand-1 forwarding select for EX
- fw_sel_rs2_o  out  fw_sel_e  operand-2 forwarding select for EX
- stall_o  out  1  load-use stall: hold PC and IF/ID, inject bubble into EX
- hazard_err_o  out  1  EX source matches a load still in MEM (protocol violation)
- stall_cnt_o  out  32  stall-cycle count (present only with FWD_STALL_CNT_EN)

Function
REQ-003 Shadow pipeline: on every clk edge, MEM shadow {mem_valid, mem_rd, mem_we, mem_ld} SHALL load {ex_valid_i, ex_rd_addr_i, ex_reg_write_i, ex_mem_read_i}, and WB shadow {wb_valid, wb_rd, wb_we} SHALL load the MEM shadow.
REQ-004 Shadows SHALL advance every cycle regardless of stall_o; the core supplies the bubble in EX.
REQ-005 A shadow SHALL count as a producer only when valid=1, we=1 and rd!=0.
REQ-006 fw_sel_rsN_o SHALL be combinational from current EX inputs and shadow registers (zero-cycle latency), evaluated independently for rs1 and rs2.
REQ-007 The MEM producer SHALL drive FW_MEM_ALU when rsN==mem_rd and mem_ld=0.
REQ-008 Otherwise, the WB producer SHALL drive FW_WB_DATA when rsN==wb_rd.
REQ-009 Otherwise, the select SHALL be FW_NONE.
REQ-010 MEM SHALL take priority over WB when both match (youngest producer wins).
REQ-011 rsN==0 SHALL always yield FW_NONE.
REQ-012 ex_valid_i=0 SHALL force both selects to FW_NONE.
REQ-013 When MEM is a load with rsN==mem_rd, the select SHALL be FW_NONE and hazard_err_o=1, asserted combinationally in that cycle only.
REQ-014 stall_o SHALL be 1 when all of the following hold:
- id_valid_i=1, ex_valid_i=1, ex_mem_read_i=1, ex_reg_write_i=1 and ex_rd_addr_i!=0; and
- (id_rs1_used_i and id_rs1_addr_i==ex_rd_addr_i) or (id_rs2_used_i and id_rs2_addr_i==ex_rd_addr_i).
REQ-015 stall_o SHALL be combinational and last exactly one cycle per load-use pair under correct core behaviour; the next cycle EX holds a bubble, so stall_o drops.
REQ-016 Back-to-back loads SHALL be evaluated independently each cycle, with no internal stall state beyond the shadows.

Reset
REQ-017 rst_n low SHALL asynchronously clear all shadow fields to 0 and stall_cnt_o to 0.
REQ-018 During and immediately after reset, fw_sel_rs1_o/fw_sel_rs2_o SHALL be FW_NONE and hazard_err_o SHALL be 0 whenever ex_valid_i=0.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight producers; the first post-reset instruction SHALL never be forwarded.

Configuration
REQ-020 Macro FWD_STALL_CNT_EN defined: stall_cnt_o SHALL exist as a 32-bit counter.
- Increments on each clk edge where stall_o=1.
- Wraps from 0xFFFF_FFFF to 0.
REQ-021 Macro FWD_STALL_CNT_EN undefined: stall_cnt_o and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 add x5 (EX) then sub x6,x5,x5 next cycle -> fw_sel_rs1_o=fw_sel_rs2_o=FW_MEM_ALU, stall_o=0.
REQ-023 add x5; nop; or x7,x5,x0 -> when or is in EX, fw_sel_rs1_o=FW_WB_DATA and fw_sel_rs2_o=FW_NONE (x0).
REQ-024 add x5 (WB) and addi x5 (MEM), EX reads x5 -> FW_MEM_ALU.
REQ-025 lw x8 in EX, ID add x9,x8,x1 -> stall_o=1 for one cycle; after the bubble, EX add gets fw_sel_rs1_o=FW_WB_DATA.
- With FWD_STALL_CNT_EN, stall_cnt_o goes 0->1.
REQ-026 lw x0 in EX, ID reads x0 -> stall_o=0.
- Writer to x0 followed by a reader of x0 -> FW_NONE.
REQ-027 Producer add x5 in MEM, rst_n pulsed low for one cycle, reader of x5 issued after reset -> FW_NONE, hazard_err_o=0.
